// File: rtl/jc_pkg.sv
// jc_pkg: shared types and constants for the Johnson-code phase decoder.
// Holds the decoder FSM state enum, the eight legal 4-bit Johnson codes
// in phase order, and the phase index width.
package jc_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } jc_state_t;

    localparam logic [3:0] JC_CODE_0 = 4'b0000;
    localparam logic [3:0] JC_CODE_1 = 4'b1000;
    localparam logic [3:0] JC_CODE_2 = 4'b1100;
    localparam logic [3:0] JC_CODE_3 = 4'b1110;
    localparam logic [3:0] JC_CODE_4 = 4'b1111;
    localparam logic [3:0] JC_CODE_5 = 4'b0111;
    localparam logic [3:0] JC_CODE_6 = 4'b0011;
    localparam logic [3:0] JC_CODE_7 = 4'b0001;

    function automatic logic [7:0] phase_onehot(input logic [PHASE_W-1:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/jc_code_lut.sv
// jc_code_lut: purely combinational lookup from a 4-bit Johnson code to
// its phase index. The eight codes that can never appear in a healthy
// 4-bit Johnson ring decode as illegal with index 0.
module jc_code_lut
    import jc_pkg::*;
(
    input  logic [3:0]         jc_in,
    output logic               legal,
    output logic [PHASE_W-1:0] idx
);

    // Map each legal code to its position in the ring; anything else is illegal.
    always_comb begin
        legal = 1'b1;
        idx   = '0;
        case (jc_in)
            JC_CODE_0: idx = 3'd0;
            JC_CODE_1: idx = 3'd1;
            JC_CODE_2: idx = 3'd2;
            JC_CODE_3: idx = 3'd3;
            JC_CODE_4: idx = 3'd4;
            JC_CODE_5: idx = 3'd5;
            JC_CODE_6: idx = 3'd6;
            JC_CODE_7: idx = 3'd7;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/jc_phase_decoder.sv
// jc_phase_decoder: samples the upstream Johnson code on each valid cycle,
// decodes phase index / one-hot phase, tracks successor correctness to
// acquire and hold lock, counts locked revolutions and flags lock loss.
// Optional macro JC_DEC_ERR_CNT_EN adds a saturating 8-bit error counter
// output err_cnt; without it the port and register do not exist.
module jc_phase_decoder
    import jc_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         jc_in,
    input  logic               jc_vld,
    input  logic               clr_err,
    output logic [PHASE_W-1:0] phase_idx,
    output logic [7:0]         phase_oh,
    output logic               locked,
    output logic               rev_pulse,
    output logic [CNT_W-1:0]   rev_cnt,
    output logic               err_pulse,
    output logic               err_sticky
`ifdef JC_DEC_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    jc_state_t           state, state_nxt;
    logic                ref_vld, ref_vld_nxt;
    logic [PHASE_W-1:0]  ref_idx, ref_idx_nxt;
    logic [3:0]          run, run_nxt;
    logic [PHASE_W-1:0]  phase_idx_nxt;
    logic [7:0]          phase_oh_nxt;
    logic                rev_pulse_nxt;
    logic [CNT_W-1:0]    rev_cnt_nxt;
    logic                err_pulse_nxt;
    logic                err_sticky_nxt;
    logic                lut_legal;
    logic [PHASE_W-1:0]  lut_idx;
    logic [PHASE_W-1:0]  ref_succ;
    logic                succ_ok;
`ifdef JC_DEC_ERR_CNT_EN
    logic [7:0]          err_cnt_nxt;
`endif

    jc_code_lut u_lut (
        .jc_in (jc_in),
        .legal (lut_legal),
        .idx   (lut_idx)
    );

    assign ref_succ = ref_idx + 3'd1;
    assign succ_ok  = ref_vld && lut_legal && (lut_idx == ref_succ);
    assign locked   = (state == LOCKED);

    // Next-state logic: lock acquisition/loss, decode outputs, counters and flags.
    always_comb begin
        state_nxt      = state;
        ref_vld_nxt    = ref_vld;
        ref_idx_nxt    = ref_idx;
        run_nxt        = run;
        phase_idx_nxt  = phase_idx;
        phase_oh_nxt   = phase_oh;
        rev_pulse_nxt  = 1'b0;
        rev_cnt_nxt    = rev_cnt;
        err_pulse_nxt  = 1'b0;
        if (jc_vld) begin
            if (lut_legal) begin
                phase_idx_nxt = lut_idx;
                phase_oh_nxt  = phase_onehot(lut_idx);
            end else begin
                phase_oh_nxt  = '0;
            end
            case (state)
                HUNT: begin
                    if (!lut_legal) begin
                        ref_vld_nxt = 1'b0;
                        run_nxt     = '0;
                    end else if (succ_ok) begin
                        ref_idx_nxt = lut_idx;
                        run_nxt     = run + 4'd1;
                        if (run + 4'd1 == LOCK_TGT) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        ref_vld_nxt = 1'b1;
                        ref_idx_nxt = lut_idx;
                        run_nxt     = '0;
                    end
                end
                LOCKED: begin
                    if (succ_ok) begin
                        ref_idx_nxt = lut_idx;
                        if (ref_idx == 3'd7) begin
                            rev_pulse_nxt = 1'b1;
                            rev_cnt_nxt   = rev_cnt + CNT_W'(1);
                        end
                    end else begin
                        err_pulse_nxt = 1'b1;
                        state_nxt     = HUNT;
                        run_nxt       = '0;
                        ref_vld_nxt   = lut_legal;
                        if (lut_legal) begin
                            ref_idx_nxt = lut_idx;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        err_sticky_nxt = err_sticky;
        if (err_pulse_nxt) begin
            err_sticky_nxt = 1'b1;
        end else if (clr_err) begin
            err_sticky_nxt = 1'b0;
        end
    end

`ifdef JC_DEC_ERR_CNT_EN
    // Error counter: clear has priority over increment, but a same-cycle error still counts as one.
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (clr_err) begin
            err_cnt_nxt = err_pulse_nxt ? 8'd1 : 8'd0;
        end else if (err_pulse_nxt && (err_cnt != 8'hFF)) begin
            err_cnt_nxt = err_cnt + 8'd1;
        end
    end

    // Error counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt_nxt;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            ref_vld    <= 1'b0;
            ref_idx    <= '0;
            run        <= '0;
            phase_idx  <= '0;
            phase_oh   <= '0;
            rev_pulse  <= 1'b0;
            rev_cnt    <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            ref_vld    <= ref_vld_nxt;
            ref_idx    <= ref_idx_nxt;
            run        <= run_nxt;
            phase_idx  <= phase_idx_nxt;
            phase_oh   <= phase_oh_nxt;
            rev_pulse  <= rev_pulse_nxt;
            rev_cnt    <= rev_cnt_nxt;
            err_pulse  <= err_pulse_nxt;
            err_sticky <= err_sticky_nxt;
        end
    end

endmodule

// File: doc/jc_phase_decoder.md
# jc_phase_decoder

Downstream consumer of the 4-bit Johnson counter: samples the Johnson code each valid cycle and decodes it to a phase index and one-hot phase. It checks that every sample is a legal Johnson state and the correct successor of the previous one, and locks after a run of correct transitions. It counts completed revolutions and flags sequence errors for the sequencing logic that follows.

## Interface
- LOCK_CNT, 4, consecutive correct successor transitions required to enter LOCKED (1..15)
- CNT_W, 16, width of revolution counter
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- jc_in  input  4  Johnson code from upstream counter
- jc_vld  input  1  jc_in sampled only when high
- clr_err  input  1  clears err_sticky (and err_cnt when enabled)
- phase_idx  output  3  decoded index of last legal sample
- phase_oh  output  8  one-hot of phase_idx; 0 after an illegal sample
- locked  output  1  high in LOCKED state
- rev_pulse  output  1  one-cycle pulse on locked 7->0 wrap
- rev_cnt  output  CNT_W  completed revolutions while locked
- err_pulse  output  1  one-cycle pulse on loss of lock
- err_sticky  output  1  set by err_pulse, held until clr_err

## Operation
- Legal codes → index: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7; other 8 codes illegal.
- Correct successor: idx_new == (idx_ref + 1) mod 8, evaluated only between consecutive jc_vld samples; gaps in jc_vld are ignored.
- FSM states HUNT (reset), LOCKED.
- HUNT: illegal sample → ref_vld=0, run=0. Legal sample with no ref, or wrong successor → new reference, run=0. Correct successor → run+1; when run reaches LOCK_CNT, go LOCKED on the same edge.
- LOCKED: correct successor → stay; idx 7→0 → rev_pulse=1, rev_cnt+1 (wraps mod 2^CNT_W, no saturation). Illegal or wrong successor → err_pulse=1, go HUNT, run=0; a legal sample becomes the new reference.
- rev_cnt holds its value through loss of lock; it is cleared only by reset.
- phase_idx/phase_oh update on every legal sample in either state; an illegal sample drives phase_oh to 0 and holds phase_idx.
- Simultaneous clr_err and err_pulse: set wins, err_sticky=1.

## Timing
- All outputs registered; a sample on edge N is reflected in the outputs after edge N.
- Reset values: phase_idx=0, phase_oh=0, locked=0, rev_pulse=0, rev_cnt=0, err_pulse=0, err_sticky=0, err_cnt=0; FSM=HUNT, ref_vld=0, run=0.
- rst_n low for mid-operation edges: all state returns to reset values on that edge, no pulses generated.
- Minimum lock time from reset with continuous valid legal sequence: LOCK_CNT+1 samples.
- jc_vld low: all state holds; rev_pulse/err_pulse deassert.

## Configuration
- JC_DEC_ERR_CNT_EN defined: adds output err_cnt [7:0], increments on each err_pulse, saturates at 255, cleared by clr_err; clr_err with a simultaneous error gives err_cnt=1.
- Undefined: no err_cnt port or register; all other behaviour identical.

## Structure
- Shared package jc_pkg: FSM state enum (HUNT, LOCKED), the 8 legal code constants, PHASE_W=3.
- One combinational sub-module jc_code_lut: jc_in → {legal, idx[2:0]}; the FSM, counters and flags sit in jc_phase_decoder.

## Test plan
- Reset, then feed the upstream sequence 0000,1000,...,0001 continuously → locked rises after the 5th sample (LOCK_CNT=4); phase_oh tracks 8'h01,8'h02,...
- Locked, run 3 full revolutions → three rev_pulse, rev_cnt=3, err_sticky=0.
- Locked, inject 1010 → err_pulse once, locked=0, phase_oh=0, err_sticky=1; then the legal sequence resumes → relock after LOCK_CNT+1 samples, rev_cnt unchanged.
- Locked, skip phase (1100 then 1111) → err_pulse, HUNT with reference idx=4; next 0111 gives run=1.
- jc_vld toggled 1/0 during a legal sequence → lock and counts identical to the continuous case; clr_err in the same cycle as an error → err_sticky stays 1.
- With JC_DEC_ERR_CNT_EN, 300 forced errors → err_cnt=255; clr_err → 0; rst_n low mid-revolution → all outputs 0 on the next edge.
